// File: rtl/cal_pkg.sv
// rtl/cal_pkg.sv - shared field codes, reset values and month-length helper for the calendar core
package cal_pkg;

    localparam logic [2:0] FLD_SEC  = 3'd0;
    localparam logic [2:0] FLD_MIN  = 3'd1;
    localparam logic [2:0] FLD_HOUR = 3'd2;
    localparam logic [2:0] FLD_DAY  = 3'd3;
    localparam logic [2:0] FLD_MON  = 3'd4;
    localparam logic [2:0] FLD_YEAR = 3'd5;
    localparam logic [2:0] FLD_WDAY = 3'd6;

    localparam logic [7:0] RST_YEAR  = 8'd0;
    localparam logic [7:0] RST_MONTH = 8'd1;
    localparam logic [7:0] RST_DAY   = 8'd1;
    localparam logic [7:0] RST_HOUR  = 8'd0;
    localparam logic [7:0] RST_MIN   = 8'd0;
    localparam logic [7:0] RST_SEC   = 8'd0;

    // Year is an offset from 2000, so every multiple of four in range is a leap year.
    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [7:0] year);
        logic [7:0] dim;
        case (month)
            8'd2:                      dim = (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11:   dim = 8'd30;
            default:                   dim = 8'd31;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// rtl/alarm_channel.sv - one alarm slot: stored hh:mm/enable and sticky hit flag
module alarm_channel (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic [4:0] wr_hour_i,
    input  logic [5:0] wr_min_i,
    input  logic       wr_en_i,
    input  logic       ack_i,
    input  logic       match_en_i,
    input  logic [7:0] nxt_hour_i,
    input  logic [7:0] nxt_min_i,
    input  logic [7:0] nxt_sec_i,
    output logic       hit_o
);

    logic [4:0] hour_q;
    logic [5:0] min_q;
    logic       en_q;
    logic       hit_q, hit_d;
    logic       match;

    // Matching on next-state time makes the flag rise together with the hh:mm:00 display.
    assign match = en_q && match_en_i && (nxt_sec_i == 8'd0) &&
                   (nxt_hour_i == {3'b000, hour_q}) && (nxt_min_i == {2'b00, min_q});

    always_comb begin
        hit_d = hit_q;
        if (match) begin
            hit_d = 1'b1;
        end else if (ack_i || wr_i) begin
            hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hour_q <= 5'd0;
            min_q  <= 6'd0;
            en_q   <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            if (wr_i) begin
                hour_q <= wr_hour_i;
                min_q  <= wr_min_i;
                en_q   <= wr_en_i;
            end
            hit_q <= hit_d;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/calendar_alarm_core.sv
// rtl/calendar_alarm_core.sv - 1 Hz calendar/clock with field load port and alarm channels
module calendar_alarm_core
    import cal_pkg::*;
#(
    parameter int NUM_ALARMS  = 2,
    parameter int YEAR_MAX    = 99,
    parameter int RST_WEEKDAY = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  mode_12h,
    input  logic                  load_en,
    input  logic [2:0]            load_field,
    input  logic [7:0]            load_value,
    output logic                  load_err,
    input  logic                  alarm_wr,
    input  logic [2:0]            alarm_sel,
    input  logic [4:0]            alarm_hour,
    input  logic [5:0]            alarm_min,
    input  logic                  alarm_en_in,
    input  logic [NUM_ALARMS-1:0] alarm_ack,
    output logic [7:0]            year,
    output logic [7:0]            month,
    output logic [7:0]            day,
    output logic [7:0]            hour,
    output logic [7:0]            minute,
    output logic [7:0]            second,
    output logic [7:0]            disp_hour,
    output logic                  pm,
    output logic [2:0]            weekday,
    output logic [NUM_ALARMS-1:0] alarm_hit
);

    localparam logic [7:0] YEAR_MAX_L = 8'(YEAR_MAX);
    localparam logic [2:0] RST_WDAY_L = 3'(RST_WEEKDAY);

    logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [7:0] day_q, day_d, month_q, month_d, year_q, year_d;
    logic [2:0] wday_q, wday_d;
    logic       err_q, err_d;
    logic       ld_err, tick_adv;
    logic [7:0] dim_cur, dim_mon, dim_yr;
    logic       alarm_range_ok, alarm_sel_ok;

    assign dim_cur = days_in_month(month_q, year_q);
    assign dim_mon = days_in_month(load_value, year_q);
    assign dim_yr  = days_in_month(month_q, load_value);

    assign alarm_range_ok = (alarm_hour <= 5'd23) && (alarm_min <= 6'd59);
    assign alarm_sel_ok   = (32'(alarm_sel) < NUM_ALARMS);

    always_comb begin
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        day_d    = day_q;
        month_d  = month_q;
        year_d   = year_q;
        wday_d   = wday_q;
        ld_err   = 1'b0;
        tick_adv = 1'b0;
        if (load_en) begin
            // A load in a tick cycle swallows that tick entirely.
            case (load_field)
                FLD_SEC:  if (load_value <= 8'd59) sec_d  = load_value; else ld_err = 1'b1;
                FLD_MIN:  if (load_value <= 8'd59) min_d  = load_value; else ld_err = 1'b1;
                FLD_HOUR: if (load_value <= 8'd23) hour_d = load_value; else ld_err = 1'b1;
                FLD_DAY: begin
                    if (load_value >= 8'd1 && load_value <= dim_cur) day_d = load_value;
                    else ld_err = 1'b1;
                end
                FLD_MON: begin
                    if (load_value >= 8'd1 && load_value <= 8'd12) begin
                        month_d = load_value;
                        if (day_q > dim_mon) day_d = dim_mon;
                    end else begin
                        ld_err = 1'b1;
                    end
                end
                FLD_YEAR: begin
                    if (load_value <= YEAR_MAX_L) begin
                        year_d = load_value;
                        if (day_q > dim_yr) day_d = dim_yr;
                    end else begin
                        ld_err = 1'b1;
                    end
                end
                FLD_WDAY: if (load_value <= 8'd6) wday_d = load_value[2:0]; else ld_err = 1'b1;
                default:  ld_err = 1'b1;
            endcase
        end else if (tick) begin
            tick_adv = 1'b1;
            if (sec_q == 8'd59) begin
                sec_d = 8'd0;
                if (min_q == 8'd59) begin
                    min_d = 8'd0;
                    if (hour_q == 8'd23) begin
                        hour_d = 8'd0;
                        wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
                        if (day_q == dim_cur) begin
                            day_d = 8'd1;
                            if (month_q == 8'd12) begin
                                month_d = 8'd1;
                                year_d  = (year_q == YEAR_MAX_L) ? 8'd0 : year_q + 8'd1;
                            end else begin
                                month_d = month_q + 8'd1;
                            end
                        end else begin
                            day_d = day_q + 8'd1;
                        end
                    end else begin
                        hour_d = hour_q + 8'd1;
                    end
                end else begin
                    min_d = min_q + 8'd1;
                end
            end else begin
                sec_d = sec_q + 8'd1;
            end
        end
        err_d = ld_err | (alarm_wr & alarm_sel_ok & ~alarm_range_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q   <= RST_SEC;
            min_q   <= RST_MIN;
            hour_q  <= RST_HOUR;
            day_q   <= RST_DAY;
            month_q <= RST_MONTH;
            year_q  <= RST_YEAR;
            wday_q  <= RST_WDAY_L;
            err_q   <= 1'b0;
        end else begin
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            wday_q  <= wday_d;
            err_q   <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_alarm
        alarm_channel u_alarm_channel (
            .clk        (clk),
            .rst        (rst),
            .wr_i       (alarm_wr && (alarm_sel == 3'(g)) && alarm_range_ok),
            .wr_hour_i  (alarm_hour),
            .wr_min_i   (alarm_min),
            .wr_en_i    (alarm_en_in),
            .ack_i      (alarm_ack[g]),
            .match_en_i (tick_adv),
            .nxt_hour_i (hour_d),
            .nxt_min_i  (min_d),
            .nxt_sec_i  (sec_d),
            .hit_o      (alarm_hit[g])
        );
    end

    always_comb begin
        disp_hour = hour_q;
        if (mode_12h) begin
            if (hour_q == 8'd0) begin
                disp_hour = 8'd12;
            end else if (hour_q > 8'd12) begin
                disp_hour = hour_q - 8'd12;
            end
        end
    end

    assign pm       = (hour_q >= 8'd12);
    assign year     = year_q;
    assign month    = month_q;
    assign day      = day_q;
    assign hour     = hour_q;
    assign minute   = min_q;
    assign second   = sec_q;
    assign weekday  = wday_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_calendar_alarm_core.sv
// tb/tb_calendar_alarm_core.sv - directed and randomized bench with a seconds-of-day calendar model
module tb_calendar_alarm_core;

    localparam int NA = 2;
    localparam int YM = 99;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1, tick = 1'b0, mode_12h = 1'b0, load_en = 1'b0;
    logic [2:0]    load_field = 3'd0;
    logic [7:0]    load_value = 8'd0;
    logic          load_err;
    logic          alarm_wr = 1'b0;
    logic [2:0]    alarm_sel = 3'd0;
    logic [4:0]    alarm_hour = 5'd0;
    logic [5:0]    alarm_min = 6'd0;
    logic          alarm_en_in = 1'b0;
    logic [NA-1:0] alarm_ack = '0;
    logic [7:0]    year, month, day, hour, minute, second, disp_hour;
    logic          pm;
    logic [2:0]    weekday;
    logic [NA-1:0] alarm_hit;

    int checks = 0;
    int errors = 0;

    int m_y, m_mo, m_d, m_h, m_mi, m_s, m_wd;
    bit m_err;
    int a_h[NA];
    int a_m[NA];
    bit a_en[NA];
    bit m_hit[NA];

    calendar_alarm_core #(.NUM_ALARMS(NA), .YEAR_MAX(YM), .RST_WEEKDAY(RW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .mode_12h(mode_12h), .load_en(load_en),
        .load_field(load_field), .load_value(load_value), .load_err(load_err),
        .alarm_wr(alarm_wr), .alarm_sel(alarm_sel), .alarm_hour(alarm_hour),
        .alarm_min(alarm_min), .alarm_en_in(alarm_en_in), .alarm_ack(alarm_ack),
        .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
        .second(second), .disp_hour(disp_hour), .pm(pm), .weekday(weekday),
        .alarm_hit(alarm_hit)
    );

    always #5 clk = ~clk;

    function automatic int mdays(input int mo, input int yr);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo == 2 && (yr % 4) == 0) return 29;
        return tbl[mo - 1];
    endfunction

    function automatic logic [NA-1:0] exp_hit();
        logic [NA-1:0] v;
        for (int i = 0; i < NA; i++) v[i] = m_hit[i];
        return v;
    endfunction

    function automatic int exp_disp(input int h, input bit m12);
        if (!m12) return h;
        return ((h % 12) == 0) ? 12 : (h % 12);
    endfunction

    task automatic model_update();
        bit adv;
        bit e;
        int v;
        int sod;
        if (rst) begin
            m_y = 0; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0; m_wd = RW; m_err = 0;
            for (int i = 0; i < NA; i++) begin
                a_h[i] = 0; a_m[i] = 0; a_en[i] = 0; m_hit[i] = 0;
            end
            return;
        end
        adv = 0;
        e = 0;
        v = int'(load_value);
        if (load_en) begin
            case (int'(load_field))
                0: if (v <= 59) m_s = v; else e = 1;
                1: if (v <= 59) m_mi = v; else e = 1;
                2: if (v <= 23) m_h = v; else e = 1;
                3: if (v >= 1 && v <= mdays(m_mo, m_y)) m_d = v; else e = 1;
                4: if (v >= 1 && v <= 12) begin
                       m_mo = v;
                       if (m_d > mdays(m_mo, m_y)) m_d = mdays(m_mo, m_y);
                   end else e = 1;
                5: if (v <= YM) begin
                       m_y = v;
                       if (m_d > mdays(m_mo, m_y)) m_d = mdays(m_mo, m_y);
                   end else e = 1;
                6: if (v <= 6) m_wd = v; else e = 1;
                default: e = 1;
            endcase
        end else if (tick) begin
            adv = 1;
            sod = m_h * 3600 + m_mi * 60 + m_s + 1;
            if (sod == 86400) begin
                sod = 0;
                m_wd = (m_wd + 1) % 7;
                m_d++;
                if (m_d > mdays(m_mo, m_y)) begin
                    m_d = 1;
                    m_mo++;
                    if (m_mo > 12) begin
                        m_mo = 1;
                        m_y = (m_y == YM) ? 0 : m_y + 1;
                    end
                end
            end
            m_h = sod / 3600;
            m_mi = (sod / 60) % 60;
            m_s = sod % 60;
        end
        for (int i = 0; i < NA; i++) begin
            bit wr_ok;
            wr_ok = alarm_wr && int'(alarm_sel) == i && alarm_hour <= 23 && alarm_min <= 59;
            if (alarm_ack[i] || wr_ok) m_hit[i] = 0;
            if (adv && a_en[i] && m_s == 0 && m_h == a_h[i] && m_mi == a_m[i]) m_hit[i] = 1;
            if (wr_ok) begin
                a_h[i] = int'(alarm_hour); a_m[i] = int'(alarm_min); a_en[i] = alarm_en_in;
            end
        end
        if (alarm_wr && int'(alarm_sel) < NA && (alarm_hour > 23 || alarm_min > 59)) e = 1;
        m_err = e;
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        rst = 1'b0; tick = 1'b0; load_en = 1'b0; alarm_wr = 1'b0; alarm_ack = '0;
    endtask

    task automatic do_load(input int f, input int v);
        load_field = 3'(f);
        load_value = 8'(v);
        load_en = 1'b1;
        cycle();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        checks++;
        if ({year, month, day, hour, minute, second} !== {8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0}) begin
            errors++; $display("FAIL reset_date got %0d-%0d-%0d %0d:%0d:%0d want 0-1-1 0:0:0", year, month, day, hour, minute, second);
        end
        checks++;
        if ({weekday, alarm_hit, load_err, pm, disp_hour} !== {3'd6, 2'b00, 1'b0, 1'b0, 8'd0}) begin
            errors++; $display("FAIL reset_misc got wd=%0d hit=%b err=%b pm=%b disp=%0d want 6 00 0 0 0", weekday, alarm_hit, load_err, pm, disp_hour);
        end
        mode_12h = 1'b1;
        #1;
        checks++;
        if (disp_hour !== 8'd12) begin
            errors++; $display("FAIL reset_disp12 got %0d want 12", disp_hour);
        end
        mode_12h = 1'b0;
        do_tick();
        checks++;
        if ({year, month, day, hour, minute, second, weekday, alarm_hit} !==
            {8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 3'd6, 2'b00}) begin
            errors++; $display("FAIL first_tick got %0d-%0d-%0d %0d:%0d:%0d wd=%0d hit=%b want 0-1-1 0:0:1 wd=6 hit=00",
                               year, month, day, hour, minute, second, weekday, alarm_hit);
        end
    endtask

    task automatic test_leap();
        do_load(5, 24); do_load(4, 2); do_load(3, 28);
        do_load(2, 23); do_load(1, 59); do_load(0, 59); do_load(6, 3);
        do_tick();
        checks++;
        if ({year, month, day, hour, minute, second, weekday} !== {8'd24, 8'd2, 8'd29, 8'd0, 8'd0, 8'd0, 3'd4}) begin
            errors++; $display("FAIL leap_feb29 got %0d-%0d-%0d %0d:%0d:%0d wd=%0d want 24-2-29 0:0:0 wd=4",
                               year, month, day, hour, minute, second, weekday);
        end
        do_load(5, 23);
        checks++;
        if (day !== 8'd28) begin
            errors++; $display("FAIL year_clamp got day %0d want 28", day);
        end
        do_load(2, 23); do_load(1, 59); do_load(0, 59);
        do_tick();
        checks++;
        if ({year, month, day, hour, minute, second, weekday} !== {8'd23, 8'd3, 8'd1, 8'd0, 8'd0, 8'd0, 3'd5}) begin
            errors++; $display("FAIL nonleap_mar1 got %0d-%0d-%0d %0d:%0d:%0d wd=%0d want 23-3-1 0:0:0 wd=5",
                               year, month, day, hour, minute, second, weekday);
        end
        do_load(5, 99); do_load(4, 12); do_load(3, 31); do_load(2, 23); do_load(1, 59); do_load(0, 59);
        do_tick();
        checks++;
        if ({year, month, day} !== {8'd0, 8'd1, 8'd1}) begin
            errors++; $display("FAIL year_wrap got %0d-%0d-%0d want 0-1-1", year, month, day);
        end
    endtask

    task automatic test_clamp();
        do_load(4, 1); do_load(3, 31); do_load(4, 4);
        checks++;
        if ({month, day, load_err} !== {8'd4, 8'd30, 1'b0}) begin
            errors++; $display("FAIL month_clamp got m=%0d d=%0d err=%b want 4 30 0", month, day, load_err);
        end
        do_load(3, 31);
        checks++;
        if ({day, load_err} !== {8'd30, 1'b1}) begin
            errors++; $display("FAIL day_reject got d=%0d err=%b want 30 1", day, load_err);
        end
        cycle();
        checks++;
        if (load_err !== 1'b0) begin
            errors++; $display("FAIL err_pulse got %b want 0", load_err);
        end
        do_load(7, 0);
        checks++;
        if (load_err !== 1'b1) begin
            errors++; $display("FAIL field7_err got %b want 1", load_err);
        end
    endtask

    task automatic test_alarm();
        alarm_wr = 1'b1; alarm_sel = 3'd1; alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en_in = 1'b1;
        cycle();
        do_load(2, 7); do_load(1, 29); do_load(0, 59);
        do_tick();
        checks++;
        if ({alarm_hit, hour, minute, second} !== {2'b10, 8'd7, 8'd30, 8'd0}) begin
            errors++; $display("FAIL alarm_fire got hit=%b %0d:%0d:%0d want 10 7:30:0", alarm_hit, hour, minute, second);
        end
        for (int i = 0; i < 5; i++) do_tick();
        checks++;
        if (alarm_hit !== 2'b10) begin
            errors++; $display("FAIL alarm_sticky got %b want 10", alarm_hit);
        end
        alarm_ack = 2'b10;
        cycle();
        checks++;
        if (alarm_hit !== 2'b00) begin
            errors++; $display("FAIL alarm_ack got %b want 00", alarm_hit);
        end
        do_load(0, 0);
        checks++;
        if ({alarm_hit, hour, minute, second} !== {2'b00, 8'd7, 8'd30, 8'd0}) begin
            errors++; $display("FAIL alarm_load got hit=%b %0d:%0d:%0d want 00 7:30:0", alarm_hit, hour, minute, second);
        end
        alarm_wr = 1'b1; alarm_sel = 3'd0; alarm_hour = 5'd24; alarm_min = 6'd0;
        cycle();
        checks++;
        if (load_err !== 1'b1) begin
            errors++; $display("FAIL alarm_range_err got %b want 1", load_err);
        end
    endtask

    task automatic test_12h();
        int hrs[4] = '{0, 12, 13, 23};
        int dsp[4] = '{12, 12, 1, 11};
        bit pms[4] = '{0, 1, 1, 1};
        mode_12h = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_load(2, hrs[i]);
            checks++;
            if ({disp_hour, pm} !== {8'(dsp[i]), pms[i]}) begin
                errors++; $display("FAIL disp12_h%0d got disp=%0d pm=%b want %0d %b", hrs[i], disp_hour, pm, dsp[i], pms[i]);
            end
        end
        mode_12h = 1'b0;
        #1;
        checks++;
        if ({disp_hour, pm} !== {8'd23, 1'b1}) begin
            errors++; $display("FAIL disp24 got disp=%0d pm=%b want 23 1", disp_hour, pm);
        end
    endtask

    task automatic test_load_tick();
        do_load(0, 17);
        load_field = 3'd1; load_value = 8'd10; load_en = 1'b1; tick = 1'b1;
        cycle();
        checks++;
        if ({minute, second} !== {8'd10, 8'd17}) begin
            errors++; $display("FAIL load_tick got %0d:%0d want 10:17", minute, second);
        end
    endtask

    task automatic test_reset_tick();
        mode_12h = 1'b1;
        do_load(2, 5);
        rst = 1'b1; tick = 1'b1; load_en = 1'b1; load_field = 3'd2; load_value = 8'd9;
        cycle();
        checks++;
        if ({year, month, day, hour, minute, second, weekday, disp_hour, pm, load_err, alarm_hit} !==
            {8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 3'd6, 8'd12, 1'b0, 1'b0, 2'b00}) begin
            errors++; $display("FAIL rst_priority got %0d-%0d-%0d %0d:%0d:%0d wd=%0d disp=%0d", year, month, day, hour, minute, second, weekday, disp_hour);
        end
        mode_12h = 1'b0;
    endtask

    task automatic test_random();
        int f;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            tick = ($urandom_range(0, 1) == 1);
            mode_12h = ($urandom_range(0, 3) == 0);
            load_en = ($urandom_range(0, 4) == 0);
            f = $urandom_range(0, 7);
            load_field = 3'(f);
            if ($urandom_range(0, 2) == 0) load_value = 8'($urandom_range(0, 255));
            else if (f <= 1) load_value = 8'($urandom_range(55, 60));
            else if (f == 2) load_value = 8'($urandom_range(21, 24));
            else if (f == 3) load_value = 8'($urandom_range(27, 32));
            else load_value = 8'($urandom_range(0, 13));
            alarm_wr = ($urandom_range(0, 9) == 0);
            alarm_sel = 3'($urandom_range(0, 3));
            alarm_en_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                alarm_hour = 5'(m_h);
                alarm_min = 6'((m_mi + 1) % 60);
            end else begin
                alarm_hour = 5'($urandom_range(0, 25));
                alarm_min = 6'($urandom_range(0, 62));
            end
            alarm_ack = ($urandom_range(0, 7) == 0) ? NA'($urandom_range(0, 3)) : '0;
            cycle();
            checks++;
            if ({year, month, day, hour, minute, second, weekday} !==
                {8'(m_y), 8'(m_mo), 8'(m_d), 8'(m_h), 8'(m_mi), 8'(m_s), 3'(m_wd)}) begin
                errors++; $display("FAIL rand_time n=%0d got %0d-%0d-%0d %0d:%0d:%0d wd=%0d want %0d-%0d-%0d %0d:%0d:%0d wd=%0d",
                                   n, year, month, day, hour, minute, second, weekday, m_y, m_mo, m_d, m_h, m_mi, m_s, m_wd);
            end
            checks++;
            if ({alarm_hit, load_err} !== {exp_hit(), m_err}) begin
                errors++; $display("FAIL rand_flags n=%0d got hit=%b err=%b want hit=%b err=%b", n, alarm_hit, load_err, exp_hit(), m_err);
            end
            checks++;
            if ({disp_hour, pm} !== {8'(exp_disp(m_h, mode_12h)), (m_h >= 12)}) begin
                errors++; $display("FAIL rand_disp n=%0d got disp=%0d pm=%b want %0d %b", n, disp_hour, pm, exp_disp(m_h, mode_12h), (m_h >= 12));
            end
        end
    endtask

    initial begin
        test_reset();
        test_leap();
        test_clamp();
        test_alarm();
        test_12h();
        test_load_tick();
        test_reset_tick();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
